// File: rtl/MD_pkg.sv
// Shared types and widths for the MD motion-update datapath.
package MD_pkg;

  localparam int FLOAT_STRUCT_WIDTH = 96;
  localparam int PARTICLE_ID_WIDTH  = 8;

  // One velocity record: three single-precision components.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } float_struct;

  // Clear sequencer states of the velocity cache array.
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } vca_state_t;

endpackage

// File: rtl/vel_cache_bank.sv
// One velocity cache cell: {valid, data} simple-dual-port RAM, a two-stage
// read pipeline with write-first forwarding, and an occupancy counter.
module vel_cache_bank
  import MD_pkg::*;
#(
  parameter int DATA_WIDTH = FLOAT_STRUCT_WIDTH,
  parameter int ADDR_WIDTH = PARTICLE_ID_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_en,
  input  logic                  i_clr_last,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_valid,
  output logic                  o_rd_hit,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH:0]   o_count
);

  localparam int WORD_W = DATA_WIDTH + 1;

  // RAM word layout: bit DATA_WIDTH is the valid flag.
  logic [WORD_W-1:0]     r_mem [DEPTH];
  logic [WORD_W-1:0]     r_ram_q;

  // Shadow of the valid flags so the counter can see the previous state
  // of the written entry in the same cycle.
  logic [DEPTH-1:0]      r_vbits;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  r_p1_valid;
  logic                  r_p1_inrange;
  logic                  r_p1_fwd;
  logic [DATA_WIDTH-1:0] r_p1_fwd_data;

  logic                  r_rd_valid;
  logic                  r_rd_hit;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_wr_inrange;
  logic                  w_rd_inrange;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_fwd;
  logic                  w_prev_valid;
  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [WORD_W-1:0]     w_ram_wdata;

  assign w_wr_inrange = (int'(i_wr_addr) < DEPTH);
  assign w_rd_inrange = (int'(i_rd_addr) < DEPTH);
  assign w_wr_idx     = w_wr_inrange ? i_wr_addr : '0;
  assign w_rd_idx     = w_rd_inrange ? i_rd_addr : '0;
  // Clear owns the write port; user traffic is ignored while it runs.
  assign w_wr_acc     = i_wr_en & ~i_clr_en & w_wr_inrange;
  assign w_rd_acc     = i_rd_en & ~i_clr_en;
  assign w_fwd        = w_rd_acc & w_wr_acc & (i_wr_addr == i_rd_addr);
  assign w_prev_valid = w_wr_inrange ? r_vbits[w_wr_idx] : 1'b0;

  // Select the RAM write source: clear sequencer first, then the user port.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = '0;
    if (i_clr_en) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = i_clr_addr;
      w_ram_wdata = '0;
    end else if (w_wr_acc) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = i_wr_addr;
      w_ram_wdata = {1'b1, i_wr_data};
    end else begin
      w_ram_we    = 1'b0;
      w_ram_waddr = '0;
      w_ram_wdata = '0;
    end
  end

  // RAM write port (not resettable; invalidation comes from the clear sequencer).
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_waddr] <= w_ram_wdata;
    end
  end

  // RAM synchronous read port; returns the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (w_rd_acc) begin
      r_ram_q <= r_mem[w_rd_idx];
    end
  end

  // Read stage 1: remember the request and any same-cycle write to its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_valid    <= 1'b0;
      r_p1_inrange  <= 1'b0;
      r_p1_fwd      <= 1'b0;
      r_p1_fwd_data <= '0;
    end else begin
      r_p1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_p1_inrange  <= w_rd_inrange;
        r_p1_fwd      <= w_fwd;
        r_p1_fwd_data <= i_wr_data;
      end
    end
  end

  // Read stage 2: registered result, holding the last value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= r_p1_valid;
      if (r_p1_valid) begin
        if (!r_p1_inrange) begin
          r_rd_hit  <= 1'b0;
          r_rd_data <= '0;
        end else if (r_p1_fwd) begin
          r_rd_hit  <= 1'b1;
          r_rd_data <= r_p1_fwd_data;
        end else begin
          r_rd_hit  <= r_ram_q[DATA_WIDTH];
          r_rd_data <= r_ram_q[DATA_WIDTH] ? r_ram_q[DATA_WIDTH-1:0] : '0;
        end
      end
    end
  end

  // Occupancy: count first writes to an entry, wipe everything when a clear ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vbits <= '0;
      r_count <= '0;
    end else begin
      if (i_clr_en) begin
        if (i_clr_last) begin
          r_vbits <= '0;
          r_count <= '0;
        end
      end else if (w_wr_acc) begin
        r_vbits[w_wr_idx] <= 1'b1;
        if (!w_prev_valid && (int'(r_count) < DEPTH)) begin
          r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        end
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_hit   = r_rd_hit;
  assign o_rd_data  = r_rd_data;
  assign o_count    = r_count;

endmodule

// File: rtl/vel_cache_array.sv
// Multi-cell velocity cache: NUM_CELLS independent banks sharing one
// clear sequencer that also runs automatically after reset.
module vel_cache_array
  import MD_pkg::*;
#(
  parameter int NUM_CELLS  = 8,
  parameter int DATA_WIDTH = FLOAT_STRUCT_WIDTH,
  parameter int ADDR_WIDTH = PARTICLE_ID_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_start,
  output logic                             clear_busy,
  input  logic [NUM_CELLS-1:0]             wr_en,
  input  logic [NUM_CELLS*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_CELLS*DATA_WIDTH-1:0]  vel_in,
  input  logic [NUM_CELLS-1:0]             rd_en,
  input  logic [NUM_CELLS*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_CELLS-1:0]             rd_valid,
  output logic [NUM_CELLS-1:0]             rd_hit,
  output logic [NUM_CELLS*DATA_WIDTH-1:0]  vel_out,
  output logic [NUM_CELLS*(ADDR_WIDTH+1)-1:0] cell_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  vca_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_clear_busy;

  logic                  w_clr_en;
  logic                  w_clr_last;

  assign w_clr_en   = (r_state == S_CLEAR);
  assign w_clr_last = w_clr_en && (r_clr_addr == LAST_ADDR);
  assign clear_busy = r_clear_busy;

  // Clear sequencer: one address per cycle across all banks; a new request
  // while clearing is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_clr_addr   <= '0;
      r_clear_busy <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state      <= S_CLEAR;
            r_clr_addr   <= '0;
            r_clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_clear_busy <= 1'b0;
          end else begin
            r_clr_addr   <= r_clr_addr + ADDR_WIDTH'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_clr_addr   <= '0;
          r_clear_busy <= 1'b0;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CELLS; g++) begin : g_bank
      vel_cache_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
      ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_clr_en   (w_clr_en),
        .i_clr_last (w_clr_last),
        .i_clr_addr (r_clr_addr),
        .i_wr_en    (wr_en[g]),
        .i_wr_addr  (wr_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
        .i_wr_data  (vel_in[g*DATA_WIDTH +: DATA_WIDTH]),
        .i_rd_en    (rd_en[g]),
        .i_rd_addr  (rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
        .o_rd_valid (rd_valid[g]),
        .o_rd_hit   (rd_hit[g]),
        .o_rd_data  (vel_out[g*DATA_WIDTH +: DATA_WIDTH]),
        .o_count    (cell_count[g*(ADDR_WIDTH+1) +: (ADDR_WIDTH+1)])
      );
    end
  endgenerate

endmodule

// File: tb/tb_vel_cache_array.sv
// Directed bench for vel_cache_array: 4 cells, 32-bit data, 4-bit IDs, DEPTH=12
// so that addresses 12..15 exercise the out-of-range path.
module tb_vel_cache_array;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DP = 12;

  logic              clk;
  logic              rst;
  logic              clear_start;
  logic              clear_busy;
  logic [NC-1:0]     wr_en;
  logic [NC*AW-1:0]  wr_addr;
  logic [NC*DW-1:0]  vel_in;
  logic [NC-1:0]     rd_en;
  logic [NC*AW-1:0]  rd_addr;
  logic [NC-1:0]     rd_valid;
  logic [NC-1:0]     rd_hit;
  logic [NC*DW-1:0]  vel_out;
  logic [NC*(AW+1)-1:0] cell_count;

  int n_assert = 0;
  int n_fail   = 0;

  vel_cache_array #(
    .NUM_CELLS (NC),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .vel_in     (vel_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_hit     (rd_hit),
    .vel_out    (vel_out),
    .cell_count (cell_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en       = '0;
    rd_en       = '0;
    clear_start = 1'b0;
  endtask

  task automatic set_wr(input int c, input int a, input logic [31:0] d);
    wr_en[c]             = 1'b1;
    wr_addr[c*AW +: AW]  = AW'(a);
    vel_in[c*DW +: DW]   = d;
  endtask

  task automatic set_rd(input int c, input int a);
    rd_en[c]             = 1'b1;
    rd_addr[c*AW +: AW]  = AW'(a);
  endtask

  function automatic logic [31:0] vel(input int c);
    return vel_out[c*DW +: DW];
  endfunction

  function automatic logic [31:0] cnt(input int c);
    return 32'(cell_count[c*(AW+1) +: (AW+1)]);
  endfunction

  function automatic logic [31:0] pat(input int c, input int a);
    logic [7:0] cb;
    logic [7:0] ab;
    cb = 8'(c + 1);
    ab = 8'(a);
    return {cb, 8'hB0, ab, ab ^ 8'h5A};
  endfunction

  // Count consecutive clear_busy cycles from the current one; reads must not
  // produce results while clearing.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (clear_busy && n < 40) begin
      n++;
      chk({tag, "_no_rd"}, 32'(rd_valid), 32'h0);
      tick();
    end
  endtask

  // Back-to-back reads of addresses 0..last on all cells, checking each result.
  task automatic read_sweep(input string tag, input int last, input bit filled);
    for (int i = 0; i <= last + 2; i++) begin
      idle();
      if (i <= last) begin
        for (int c = 0; c < NC; c++) set_rd(c, i);
      end
      if (i >= 2) begin
        chk({tag, "_valid"}, 32'(rd_valid), 32'hF);
        for (int c = 0; c < NC; c++) begin
          if (filled && (i - 2) < DP) begin
            chk({tag, "_hit"}, 32'(rd_hit[c]), 32'h1);
            chk({tag, "_data"}, vel(c), pat(c, i - 2));
          end else begin
            chk({tag, "_hit"}, 32'(rd_hit[c]), 32'h0);
            chk({tag, "_data"}, vel(c), 32'h0);
          end
        end
      end
      tick();
    end
    idle();
    chk({tag, "_end"}, 32'(rd_valid), 32'h0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    clear_start = 1'b0;
    wr_en       = '0;
    wr_addr     = '0;
    vel_in      = '0;
    rd_en       = '0;
    rd_addr     = '0;

    // Reset values
    tick();
    tick();
    chk("rst_busy", 32'(clear_busy), 32'h1);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_hit", 32'(rd_hit), 32'h0);
    chk("rst_vel_out", vel(0) | vel(1) | vel(2) | vel(3), 32'h0);
    chk("rst_count", 32'(cell_count), 32'h0);
    rst = 1'b0;
    count_busy("init", n);
    chk("init_busy_len", 32'(n), 32'(DP));

    // Read of an unwritten entry misses with zero data
    set_rd(0, 5);
    tick(); idle();
    chk("t1_latency", 32'(rd_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(rd_valid), 32'h1);
    chk("t1_hit", 32'(rd_hit[0]), 32'h0);
    chk("t1_data", vel(0), 32'h0);
    chk("t1_count", cnt(0), 32'h0);

    // Write then read; overwrite keeps the count
    set_wr(2, 3, 32'hA5A5_0003);
    tick(); idle();
    set_rd(2, 3);
    chk("t2_count", cnt(2), 32'h1);
    tick(); idle();
    tick();
    chk("t2_valid", 32'(rd_valid), 32'h4);
    chk("t2_hit", 32'(rd_hit[2]), 32'h1);
    chk("t2_data", vel(2), 32'hA5A5_0003);
    set_wr(2, 3, 32'hB0B0_1234);
    tick(); idle();
    chk("t2_hold_valid", 32'(rd_valid), 32'h0);
    chk("t2_hold_data", vel(2), 32'hA5A5_0003);
    chk("t2_ovw_count", cnt(2), 32'h1);
    set_rd(2, 3);
    tick(); idle();
    tick();
    chk("t2_ovw_hit", 32'(rd_hit[2]), 32'h1);
    chk("t2_ovw_data", vel(2), 32'hB0B0_1234);

    // Same-cycle write and read forward; the next-cycle write does not leak in
    set_wr(1, 7, 32'hC0C0_0007);
    set_rd(1, 7);
    tick(); idle();
    set_wr(1, 7, 32'hD0D0_0007);
    tick(); idle();
    chk("t3_valid", 32'(rd_valid), 32'h2);
    chk("t3_hit", 32'(rd_hit[1]), 32'h1);
    chk("t3_data", vel(1), 32'hC0C0_0007);
    chk("t3_count", cnt(1), 32'h1);
    set_rd(1, 7);
    tick(); idle();
    tick();
    chk("t3_later_data", vel(1), 32'hD0D0_0007);

    // Fill every cell; the trailing write to address 14 is out of range
    for (int a = 0; a <= DP; a++) begin
      idle();
      for (int c = 0; c < NC; c++) set_wr(c, (a < DP) ? a : 14, pat(c, a));
      tick();
    end
    idle();
    for (int c = 0; c < NC; c++) chk("t4_full_count", cnt(c), 32'(DP));
    read_sweep("t4", 15, 1'b1);

    // Clear: writes, reads and a second clear_start during the sequence are ignored
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    n = 0;
    while (clear_busy && n < 40) begin
      n++;
      for (int c = 0; c < NC; c++) begin
        set_wr(c, 1, 32'hDEAD_0000 + 32'(n));
        set_rd(c, 1);
      end
      clear_start = (n == 5);
      chk("t5_no_rd", 32'(rd_valid), 32'h0);
      tick();
    end
    idle();
    chk("t5_busy_len", 32'(n), 32'(DP));
    for (int c = 0; c < NC; c++) chk("t5_count_zero", cnt(c), 32'h0);
    chk("t5_no_rd_after", 32'(rd_valid), 32'h0);
    tick();
    chk("t5_no_rd_after2", 32'(rd_valid), 32'h0);
    read_sweep("t5", DP - 1, 1'b0);

    // Reset halfway through a clear restarts it from address 0
    clear_start = 1'b1;
    tick();
    idle();
    repeat (5) tick();
    chk("t6_mid_busy", 32'(clear_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("t6a", n);
    chk("t6a_busy_len", 32'(n), 32'(DP));

    // Reset with a read in flight drops that read
    for (int c = 0; c < NC; c++) set_rd(c, 3);
    tick(); idle();
    rst = 1'b1;
    chk("t6b_rst_rd", 32'(rd_valid), 32'h0);
    tick();
    rst = 1'b0;
    chk("t6b_dropped", 32'(rd_valid), 32'h0);
    count_busy("t6b", n);
    chk("t6b_busy_len", 32'(n), 32'(DP));
    chk("t6b_count", 32'(cell_count), 32'h0);

    // Normal operation resumes after the reset-triggered clear
    set_wr(3, 4, 32'hE0E0_0004);
    set_rd(3, 4);
    tick(); idle();
    chk("t7_count", cnt(3), 32'h1);
    tick();
    chk("t7_valid", 32'(rd_valid), 32'h8);
    chk("t7_hit", 32'(rd_hit[3]), 32'h1);
    chk("t7_data", vel(3), 32'hE0E0_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
